// File: rtl/matmul_sequencer_pkg.sv
// Shared widths for the matmul datapath and its run-time sequencer.
package matmul_sequencer_pkg;

    localparam int data_width  = 8;
    localparam int mem_depth   = 256;
    localparam int select      = 2;
    localparam int count_depth = 8;

    typedef logic [data_width-1:0]  word_t;
    typedef logic [select-1:0]      sel_t;
    typedef logic [count_depth-1:0] cnt_t;

endpackage

// File: rtl/matmul_sequencer_tag_delay_line.sv
// Carries the (valid, row, col) tag of each MAC issue until its result
// is due; hold freezes every stage in place.
module tag_delay_line
    import matmul_sequencer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IW    = 2,
    parameter int JW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold_i,
    input  logic          valid_i,
    input  logic [IW-1:0] row_i,
    input  logic [JW-1:0] col_i,
    output logic          valid_o,
    output logic [IW-1:0] row_o,
    output logic [JW-1:0] col_o,
    output logic          pending_o
);

    localparam logic [DEPTH-1:0] TAIL = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0] valid_q;
    logic [IW-1:0]    row_q [DEPTH];
    logic [JW-1:0]    col_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                row_q[k] <= '0;
                col_q[k] <= '0;
            end
        end else if (!hold_i) begin
            valid_q[0] <= valid_i;
            row_q[0]   <= row_i;
            col_q[0]   <= col_i;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                row_q[k]   <= row_q[k-1];
                col_q[k]   <= col_q[k-1];
            end
        end
    end

    assign valid_o   = valid_q[DEPTH-1];
    assign row_o     = row_q[DEPTH-1];
    assign col_o     = col_q[DEPTH-1];
    // Tail drains on the coming edge, so only earlier stages keep us busy.
    assign pending_o = |(valid_q & ~TAIL);

endmodule

// File: rtl/matmul_sequencer.sv
// Job sequencer: loads the input bank from ROM, streams weights against
// each bank row, and writes MAC results to RAM with a start/busy/done handshake.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int ADDR_W   = $clog2(mem_depth),
    parameter int ROWS     = 4,
    parameter int NCOL     = 4,
    parameter int SEL_W    = $clog2(ROWS),
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 4,
    parameter int OUT_BASE = 0,
    parameter int MAC_LAT  = 2,
    parameter int CNT_W    = count_depth
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_rd_en,
    output logic              bank_load_en,
    output logic [SEL_W-1:0]  bank_select_line,
    output logic [SEL_W-1:0]  select_line,
    output logic              mac_en,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [CNT_W-1:0]  count
);

    localparam int COL_W = (NCOL > 1) ? $clog2(NCOL) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_FLUSH, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              iss_load_d, iss_mac_d, done_d;
    logic [ADDR_W-1:0] rom_addr_d, ram_addr_d;

    logic              s1_load_q, s1_mac_q;
    logic [SEL_W-1:0]  s1_row_q;
    logic [COL_W-1:0]  s1_col_q;

    logic              busy_q, done_q, rom_rd_q, bank_ld_q, mac_q, wr_q;
    logic [ADDR_W-1:0] rom_addr_q, ram_addr_q;
    logic [SEL_W-1:0]  bank_sel_q, sel_q;
    logic [CNT_W-1:0]  count_q;

    logic              dl_valid, dl_pending, accept;
    logic [SEL_W-1:0]  dl_row;
    logic [COL_W-1:0]  dl_col;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        iss_load_d = 1'b0;
        iss_mac_d  = 1'b0;
        done_d     = 1'b0;
        rom_addr_d = rom_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_LOAD: begin
                iss_load_d = 1'b1;
                rom_addr_d = ADDR_W'(IN_BASE) + ADDR_W'(row_q);
                if (row_q == SEL_W'(ROWS - 1)) begin
                    row_d   = '0;
                    state_d = S_COMPUTE;
                end else begin
                    row_d = row_q + SEL_W'(1);
                end
            end
            S_COMPUTE: begin
                iss_mac_d  = 1'b1;
                rom_addr_d = ADDR_W'(W_BASE) + ADDR_W'(col_q);
                if (col_q == COL_W'(NCOL - 1)) begin
                    col_d = '0;
                    if (row_q == SEL_W'(ROWS - 1)) state_d = S_FLUSH;
                    else row_d = row_q + SEL_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            S_FLUSH: begin
                if (!s1_mac_q && !dl_pending) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    tag_delay_line #(
        .DEPTH (MAC_LAT),
        .IW    (SEL_W),
        .JW    (COL_W)
    ) u_tags (
        .clk       (clk),
        .reset     (reset),
        .hold_i    (!enable),
        .valid_i   (s1_mac_q),
        .row_i     (s1_row_q),
        .col_i     (s1_col_q),
        .valid_o   (dl_valid),
        .row_o     (dl_row),
        .col_o     (dl_col),
        .pending_o (dl_pending)
    );

    assign ram_addr_d = ADDR_W'(OUT_BASE)
                      + ADDR_W'(dl_row) * ADDR_W'(NCOL)
                      + ADDR_W'(dl_col);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            s1_load_q  <= 1'b0;
            s1_mac_q   <= 1'b0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            bank_ld_q  <= 1'b0;
            bank_sel_q <= '0;
            sel_q      <= '0;
            mac_q      <= 1'b0;
            wr_q       <= 1'b0;
            ram_addr_q <= '0;
            count_q    <= '0;
        end else begin
            // Strobes drop while frozen; everything else holds.
            rom_rd_q  <= 1'b0;
            bank_ld_q <= 1'b0;
            mac_q     <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            if (enable) begin
                state_q    <= state_d;
                row_q      <= row_d;
                col_q      <= col_d;
                s1_load_q  <= iss_load_d;
                s1_mac_q   <= iss_mac_d;
                s1_row_q   <= row_q;
                s1_col_q   <= col_q;
                busy_q     <= (state_q != S_IDLE);
                done_q     <= done_d;
                rom_rd_q   <= iss_load_d | iss_mac_d;
                rom_addr_q <= rom_addr_d;
                bank_ld_q  <= s1_load_q;
                mac_q      <= s1_mac_q;
                wr_q       <= dl_valid;
                if (s1_load_q) bank_sel_q <= s1_row_q;
                if (s1_mac_q) sel_q <= s1_row_q;
                if (dl_valid) ram_addr_q <= ram_addr_d;
                if (accept) begin
                    count_q <= '0;
                end else if (dl_valid && count_q != '1) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign rom_address      = rom_addr_q;
    assign rom_rd_en        = rom_rd_q;
    assign bank_load_en     = bank_ld_q;
    assign bank_select_line = bank_sel_q;
    assign select_line      = sel_q;
    assign mac_en           = mac_q;
    assign ram_wr_en        = wr_q;
    assign ram_address      = ram_addr_q;
    assign count            = count_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: job-timeline model plus directed and random runs
// against a default instance and one with OUT_BASE=250.
module tb_matmul_sequencer;

    localparam int ROWS  = 4;
    localparam int NCOL  = 4;
    localparam int ML    = 2;
    localparam int IN_B  = 0;
    localparam int W_B   = 4;
    localparam int NR    = ROWS * NCOL;
    localparam int D     = ROWS + NR + ML + 2;
    localparam int BASE1 = 250;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic start = 1'b0;

    logic       busy_w [2];
    logic       done_w [2];
    logic       rd_w   [2];
    logic       bl_w   [2];
    logic       mac_w  [2];
    logic       wr_w   [2];
    logic [7:0] rom_w  [2];
    logic [7:0] ram_w  [2];
    logic [7:0] cnt_w  [2];
    logic [1:0] bsel_w [2];
    logic [1:0] sel_w  [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    matmul_sequencer dut0 (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .busy(busy_w[0]), .done(done_w[0]),
        .rom_address(rom_w[0]), .rom_rd_en(rd_w[0]),
        .bank_load_en(bl_w[0]), .bank_select_line(bsel_w[0]),
        .select_line(sel_w[0]), .mac_en(mac_w[0]),
        .ram_wr_en(wr_w[0]), .ram_address(ram_w[0]), .count(cnt_w[0])
    );

    matmul_sequencer #(.OUT_BASE(BASE1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .start(start),
        .busy(busy_w[1]), .done(done_w[1]),
        .rom_address(rom_w[1]), .rom_rd_en(rd_w[1]),
        .bank_load_en(bl_w[1]), .bank_select_line(bsel_w[1]),
        .select_line(sel_w[1]), .mac_en(mac_w[1]),
        .ram_wr_en(wr_w[1]), .ram_address(ram_w[1]), .count(cnt_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Model: a job is a timeline indexed by enabled edges since acceptance.
    bit         active = 0;
    bit         seen = 0;
    int         p = 0;
    logic       m_busy, m_done, m_rd, m_bl, m_mac, m_wr;
    logic [7:0] m_rom, m_cnt;
    logic [7:0] m_ram [2];
    logic [1:0] m_bsel, m_sel;

    task automatic model_reset();
        active = 0;
        p = 0;
        {m_busy, m_done, m_rd, m_bl, m_mac, m_wr} = '0;
        m_rom = '0;
        m_cnt = '0;
        m_ram[0] = '0;
        m_ram[1] = '0;
        m_bsel = '0;
        m_sel = '0;
    endtask

    task automatic model_step(input logic en, input logic st);
        int k;
        {m_done, m_rd, m_bl, m_mac, m_wr} = '0;
        if (!en) return;
        if (!active) begin
            m_busy = 0;
            if (st) begin
                active = 1;
                p = 0;
                m_cnt = 0;
            end
            return;
        end
        p++;
        m_busy = 1;
        if (p <= ROWS) begin
            m_rd = 1;
            m_rom = 8'(IN_B + p - 1);
        end else if (p <= ROWS + NR) begin
            m_rd = 1;
            m_rom = 8'(W_B + (p - ROWS - 1) % NCOL);
        end
        if (p >= 2 && p <= ROWS + 1) begin
            m_bl = 1;
            m_bsel = 2'(p - 2);
        end
        if (p >= ROWS + 2 && p <= ROWS + NR + 1) begin
            m_mac = 1;
            m_sel = 2'((p - ROWS - 2) / NCOL);
        end
        if (p >= ROWS + 2 + ML && p <= ROWS + NR + 1 + ML) begin
            k = p - (ROWS + 2 + ML);
            m_wr = 1;
            m_ram[0] = 8'(k);
            m_ram[1] = 8'(BASE1 + k);
            if (m_cnt != 8'hff) m_cnt++;
        end
        if (p == D) begin
            m_done = 1;
            active = 0;
        end
    endtask

    initial begin
        logic rs, en, st;
        forever begin
            @(posedge clk);
            rs = reset;
            en = enable;
            st = start;
            if (!rs) begin
                model_reset();
                seen = 1;
            end else begin
                model_step(en, st);
            end
            #1;
            if (seen) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("d%0d_busy", k), busy_w[k], m_busy);
                    chk($sformatf("d%0d_done", k), done_w[k], m_done);
                    chk($sformatf("d%0d_rd", k), rd_w[k], m_rd);
                    chk($sformatf("d%0d_rom", k), rom_w[k], m_rom);
                    chk($sformatf("d%0d_bl", k), bl_w[k], m_bl);
                    chk($sformatf("d%0d_bsel", k), bsel_w[k], m_bsel);
                    chk($sformatf("d%0d_mac", k), mac_w[k], m_mac);
                    chk($sformatf("d%0d_sel", k), sel_w[k], m_sel);
                    chk($sformatf("d%0d_wr", k), wr_w[k], m_wr);
                    chk($sformatf("d%0d_ram", k), ram_w[k], m_ram[k]);
                    chk($sformatf("d%0d_cnt", k), cnt_w[k], m_cnt);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            reset = 1;
            enable = 1;
            start = 0;
        end
    endtask

    initial begin
        int nwr, nlate, act;
        logic [15:0] hit;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_cnt", cnt_w[0], 0);
        idle(3);

        // Single job; loop index t drives edge t and sees cycle t-1.
        for (int t = 0; t <= 26; t++) begin
            @(negedge clk);
            case (t - 1)
                1: begin
                    chk("t1_rom_first", rom_w[0], 0);
                    chk("t1_rd_first", rd_w[0], 1);
                end
                2: chk("t1_bank_load", bl_w[0], 1);
                5: chk("t1_rom_w0", rom_w[0], 4);
                6: chk("t1_mac_first", mac_w[0], 1);
                8: begin
                    chk("t1_wr_first", wr_w[0], 1);
                    chk("t1_ram_first", ram_w[0], 0);
                    chk("t1_wrap_first", ram_w[1], 250);
                end
                13: chk("t1_wrap_top", ram_w[1], 255);
                14: chk("t1_wrap_zero", ram_w[1], 0);
                23: begin
                    chk("t1_ram_last", ram_w[0], 15);
                    chk("t1_wrap_last", ram_w[1], 9);
                end
                24: begin
                    chk("t1_done", done_w[0], 1);
                    chk("t1_count", cnt_w[0], 16);
                    chk("t1_count_wrap", cnt_w[1], 16);
                end
                25: chk("t1_busy_off", busy_w[0], 0);
                default: ;
            endcase
            reset = 1;
            enable = 1;
            start = (t == 0);
        end
        idle(3);

        // Start held for 30 cycles.
        for (int t = 0; t <= 51; t++) begin
            @(negedge clk);
            case (t - 1)
                24: chk("t2_done1", done_w[0], 1);
                25: chk("t2_gap", busy_w[0], 0);
                26: chk("t2_busy2", busy_w[0], 1);
                49: chk("t2_done2", done_w[0], 1);
                default: ;
            endcase
            reset = 1;
            enable = 1;
            start = (t < 30);
        end
        idle(3);

        // Freeze for 3 cycles at (i=2,j=1).
        nwr = 0;
        hit = '0;
        for (int t = 0; t <= 30; t++) begin
            @(negedge clk);
            if (wr_w[0]) begin
                nwr++;
                hit[ram_w[0][3:0]] = 1'b1;
            end
            case (t - 1)
                14: chk("t3_frz_strobe", {rd_w[0], mac_w[0], wr_w[0]}, 0);
                15: chk("t3_frz_hold", rom_w[0], 4);
                17: begin
                    chk("t3_resume_rd", rd_w[0], 1);
                    chk("t3_resume_rom", rom_w[0], 5);
                end
                24: chk("t3_no_early_done", done_w[0], 0);
                27: chk("t3_done_shift", done_w[0], 1);
                default: ;
            endcase
            reset = 1;
            enable = !(t >= 14 && t <= 16);
            start = (t == 0);
        end
        chk("t3_nwrites", nwr, 16);
        chk("t3_cover", hit, 16'hffff);
        idle(3);

        // Reset during FLUSH.
        nlate = 0;
        for (int t = 0; t <= 36; t++) begin
            @(negedge clk);
            if (t - 1 >= 22 && wr_w[0]) nlate++;
            if (t - 1 == 22) begin
                chk("t4_busy", busy_w[0], 0);
                chk("t4_rom", rom_w[0], 0);
                chk("t4_sel", sel_w[0], 0);
                chk("t4_ram", ram_w[1], 0);
                chk("t4_cnt", cnt_w[0], 0);
            end
            reset = (t != 22);
            enable = 1;
            start = (t == 0);
        end
        chk("t4_no_late_wr", nlate, 0);
        idle(3);

        // Start while frozen is dropped.
        act = 0;
        for (int t = 0; t <= 12; t++) begin
            @(negedge clk);
            if (busy_w[0] || rd_w[0]) act++;
            reset = 1;
            enable = (t != 0);
            start = (t == 0);
        end
        chk("t6_dropped", act, 0);

        // Random traffic.
        for (int t = 0; t < 1500; t++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) != 0);
            enable = ($urandom_range(0, 9) != 0);
            start = ($urandom_range(0, 15) == 0);
        end
        idle(40);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Run-time sequencer for the matrix-multiply datapath. On a `start` pulse it loads the input matrix rows from the dual-port ROM into the input register bank. It then streams the weight words from the ROM against every bank row, drives the MAC enable, and issues result writes to the output RAM. It takes over the address/select/strobe generation that the free-running controller provides, and adds a start/busy/done handshake and a deterministic end of job.

## Interface
Parameters:
- `ADDR_W`, 8: ROM/RAM address width.
- `ROWS`, 4: input matrix rows held in the register bank (power of two, ≥2).
- `NCOL`, 4: weight words, one per output column.
- `SEL_W`, clog2(ROWS): bank/row select width.
- `IN_BASE`, 0: ROM address of input row 0.
- `W_BASE`, 4: ROM address of weight word 0.
- `OUT_BASE`, 0: RAM address of result (0,0).
- `MAC_LAT`, 2: cycles from `mac_en` to MAC result valid (≥1).
- `CNT_W`, 8: result counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low.
- `enable`, in, 1: global run/freeze.
- `start`, in, 1: job request pulse.
- `busy`, out, 1: job in progress.
- `done`, out, 1: one-cycle end-of-job pulse.
- `rom_address`, out, ADDR_W: ROM read address.
- `rom_rd_en`, out, 1: ROM read strobe.
- `bank_load_en`, out, 1: write the ROM data into bank row `bank_select_line`.
- `bank_select_line`, out, SEL_W: destination row for the load.
- `select_line`, out, SEL_W: bank row presented to the MAC.
- `mac_en`, out, 1: MAC consumes the bank row and the ROM weight word.
- `ram_wr_en`, out, 1: result write strobe.
- `ram_address`, out, ADDR_W: result address.
- `count`, out, CNT_W: results written in the current job.

## Operation
- States: IDLE → LOAD → COMPUTE → FLUSH → DONE → IDLE.
- IDLE: `start` is accepted only when `enable`=1. Accepting it clears `count` and enters LOAD. A `start` seen while not in IDLE is ignored.
- LOAD: runs ROWS cycles with row r = 0..ROWS-1.
  - `rom_address`=IN_BASE+r, `rom_rd_en`=1.
  - One cycle later: `bank_load_en`=1 with `bank_select_line`=r. This matches the ROM's 1-cycle read latency.
- COMPUTE: runs ROWS*NCOL cycles, row i outer and column j inner.
  - `rom_address`=W_BASE+j, `rom_rd_en`=1.
  - One cycle later: `mac_en`=1 with `select_line`=i.
- Result write: MAC_LAT cycles after each `mac_en`, `ram_wr_en`=1 with `ram_address`=OUT_BASE+i*NCOL+j, and `count` increments.
  - The (i,j) tag travels through a delay pipeline.
- The last LOAD `bank_load_en` overlaps the first COMPUTE address cycle. This is legal because the first `mac_en` follows it.
- FLUSH: waits until the delay pipeline holds no valid tag.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 from the cycle after `start` is accepted through the DONE cycle inclusive.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent. `count` saturates at 2^CNT_W-1.

## Timing
- Reset (`reset`=0 at an edge): state IDLE; every output 0, including `count`; the pipeline is cleared.
- Reset mid-job aborts with no further `ram_wr_en`.
- `enable`=0 freezes the state, counters and delay pipeline.
  - While frozen, `rom_rd_en`, `bank_load_en`, `mac_en`, `ram_wr_en` and `done` are forced to 0.
  - Addresses and selects hold their values.
  - When `enable` returns to 1, the sequence resumes exactly where it stopped; no strobe is lost or duplicated.
- A `start` arriving while `enable`=0 is dropped, not latched.
- All outputs are registered.
- Job latency at defaults, with `start` sampled at edge 0:
  - LOAD addresses: cycles 1–4.
  - COMPUTE addresses: cycles 5–20.
  - `mac_en`: cycles 6–21.
  - `ram_wr_en`: cycles 8–23.
  - `done`: cycle 24.
- General form: `done` falls at cycle ROWS+ROWS*NCOL+MAC_LAT+2.
- Back-to-back jobs: a `start` in the cycle after `done` is accepted.

## Structure
- Shared defines header holds the common widths, next to the existing data/mem-depth defines: `data_width`, `mem_depth`, `select`, `count_depth`.
- State encodings are local to this block.
- One sub-module, `tag_delay_line`: a parameterised shift register with depth MAC_LAT.
  - It carries valid, i and j.
  - It has a hold input driven by `enable`.

## Test plan
- Reset then single job at defaults: `rom_address` runs 0,1,2,3 then 4,5,6,7 ×4. `bank_select_line` runs 0..3. `ram_address` runs 0..15 on cycles 8–23. `done` at cycle 24, `count`=16.
- `start` held high for 30 cycles: exactly one job runs; a second starts only from IDLE, the cycle after `done`.
- `enable` low for 3 cycles in the middle of COMPUTE, at (i=2,j=1): strobes are 0 while frozen, `done` shifts by exactly 3 cycles, and `ram_address` still covers 0..15 with no duplicate.
- `reset` asserted during FLUSH: the next cycle has all outputs 0 and state IDLE, and no later `ram_wr_en` occurs.
- OUT_BASE=250, ROWS=4, NCOL=4: `ram_address` wraps 250..255, 0..9, and `count`=16.
- `start` with `enable`=0, then `enable`=1 without `start`: `busy` stays 0 and no ROM reads occur.
